// File: rtl/l1_trigger_event_fifo.sv
// l1_trigger_event_fifo
// Turns per-beam L1 trigger pulses into timestamped events: beams are masked,
// coalesced over a COINC_CLOCKS window that opens on the first hit, and pushed
// as {timestamp, bitmap} into a first-word-fall-through FIFO drained by a
// valid/ready handshake.
// Optional build macro: L1_EVENT_DROP_COUNT_EN adds drop_count_o, a saturating
// count of events rejected because the FIFO was full.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for the first unmasked hit to open a window
// S_GATHER | window open, OR-ing further hits into the bitmap
// S_COMMIT | pushing {ts_l, bm_l}; hits this cycle are ignored
module l1_trigger_event_fifo #(
  parameter int NBEAMS       = 2,
  parameter int COINC_CLOCKS = 4,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          aclk,
  input  logic                          reset_i,
  input  logic [NBEAMS-1:0]             trigger_i,
  input  logic [NBEAMS-1:0]             mask_i,
  output logic [32+NBEAMS-1:0]          evt_data_o,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
`ifdef L1_EVENT_DROP_COUNT_EN
  ,
  output logic [15:0]                   drop_count_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = 32 + NBEAMS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GATHER = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // Window down-counter reload: GATHER lasts COINC_CLOCKS-1 cycles, ending at zero.
  localparam logic [7:0] WIN_LOAD = 8'((COINC_CLOCKS > 1) ? (COINC_CLOCKS - 2) : 0);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  logic [31:0]       ts;
  logic [1:0]        state;
  logic [7:0]        win_cnt;
  logic [31:0]       ts_l;
  logic [NBEAMS-1:0] bm_l;
  logic [NBEAMS-1:0] hit;

  logic [DW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;
  logic              accept;

  assign hit    = trigger_i & ~mask_i;
  assign push   = (state == S_COMMIT);
  assign pop    = evt_valid_o && evt_ready_i;
  // A full FIFO still takes the event when the head leaves in the same cycle.
  assign accept = push && ((count != FULL_COUNT) || pop);

  assign evt_valid_o  = (count != '0);
  assign evt_data_o   = evt_valid_o ? mem[rd_ptr] : '0;
  assign fifo_count_o = count;

  // Free-running event timestamp.
  always_ff @(posedge aclk) begin
    if (reset_i) ts <= '0;
    else         ts <= ts + 32'd1;
  end

  // Coalescing FSM: open on first hit, gather for the window, then commit.
  always_ff @(posedge aclk) begin
    if (reset_i) begin
      state   <= S_IDLE;
      win_cnt <= '0;
      ts_l    <= '0;
      bm_l    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|hit) begin
            ts_l    <= ts;
            bm_l    <= hit;
            win_cnt <= WIN_LOAD;
            state   <= (COINC_CLOCKS > 1) ? S_GATHER : S_COMMIT;
          end
        end
        S_GATHER: begin
          bm_l <= bm_l | hit;
          if (win_cnt == '0) state <= S_COMMIT;
          else               win_cnt <= win_cnt - 8'd1;
        end
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because valid gates the output.
  always_ff @(posedge aclk) begin
    if (accept) mem[wr_ptr] <= {ts_l, bm_l};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge aclk) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef L1_EVENT_DROP_COUNT_EN
  logic [15:0] drop_cnt;
  assign drop_count_o = drop_cnt;

  // Saturating count of events rejected by a full FIFO.
  always_ff @(posedge aclk) begin
    if (reset_i)                                         drop_cnt <= '0;
    else if (push && !accept && (drop_cnt != 16'hFFFF))  drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_l1_trigger_event_fifo.sv
// Bench for l1_trigger_event_fifo: directed scenarios followed by random
// traffic, checked against a queue-based event model and a scoreboard.
module tb_l1_trigger_event_fifo;

  localparam int NB = 2;
  localparam int CC = 4;
  localparam int FD = 16;
  localparam int DW = 32 + NB;

  logic                     aclk = 1'b0;
  logic                     reset_i = 1'b1;
  logic [NB-1:0]            trigger_i = '0;
  logic [NB-1:0]            mask_i = '0;
  logic                     evt_ready_i = 1'b0;
  logic [DW-1:0]            evt_data_o;
  logic                     evt_valid_o;
  logic [$clog2(FD):0]      fifo_count_o;
`ifdef L1_EVENT_DROP_COUNT_EN
  logic [15:0]              drop_count_o;
`endif

  l1_trigger_event_fifo #(.NBEAMS(NB), .COINC_CLOCKS(CC), .FIFO_DEPTH(FD)) dut (
    .aclk         (aclk),
    .reset_i      (reset_i),
    .trigger_i    (trigger_i),
    .mask_i       (mask_i),
    .evt_data_o   (evt_data_o),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .fifo_count_o (fifo_count_o)
`ifdef L1_EVENT_DROP_COUNT_EN
    ,
    .drop_count_o (drop_count_o)
`endif
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Events are modelled as a window that opens on the first unmasked hit and
  // commits exactly CC cycles later; the FIFO is a plain queue.
  logic [DW-1:0] mdl_fifo[$];
  logic [DW-1:0] exp_q[$];
  logic [31:0]   m_ts = '0;
  bit            m_open = 0;
  int            m_left = 0;
  logic [31:0]   m_ts_l = '0;
  logic [NB-1:0] m_bm = '0;
  int            m_drop = 0;
  logic [NB-1:0] m_hit;
  bit            m_pop;
  int            m_occ;

  always @(posedge aclk) begin
    if (reset_i) begin
      mdl_fifo.delete();
      exp_q.delete();
      m_ts = '0;
      m_open = 0;
      m_drop = 0;
    end else begin
      m_hit = trigger_i & ~mask_i;
      m_occ = mdl_fifo.size();
      m_pop = (m_occ > 0) && evt_ready_i;
      if (m_pop) void'(mdl_fifo.pop_front());
      if (m_open) begin
        m_left--;
        if (m_left == 0) begin
          m_open = 0;
          if (m_occ < FD || m_pop) begin
            mdl_fifo.push_back({m_ts_l, m_bm});
            exp_q.push_back({m_ts_l, m_bm});
          end else if (m_drop < 65535) begin
            m_drop++;
          end
        end else begin
          m_bm = m_bm | m_hit;
        end
      end else if (|m_hit) begin
        m_open = 1;
        m_left = CC;
        m_ts_l = m_ts;
        m_bm = m_hit;
      end
      m_ts = m_ts + 32'd1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [DW-1:0] sb_exp;
  always @(negedge aclk) begin
    chk("valid", {63'd0, evt_valid_o}, {63'd0, mdl_fifo.size() != 0});
    chk("count", 64'(fifo_count_o), 64'(mdl_fifo.size()));
`ifdef L1_EVENT_DROP_COUNT_EN
    chk("drop_count", 64'(drop_count_o), 64'(m_drop));
`endif
    if (!evt_valid_o) chk("idle_data", 64'(evt_data_o), 64'd0);
    if (evt_valid_o && evt_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 64'(evt_data_o), 64'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("event", 64'(evt_data_o), 64'(sb_exp));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic pulse(input logic [NB-1:0] trg);
    trigger_i = trg;
    idle(1);
    trigger_i = '0;
  endtask

  initial begin
    idle(3);
    reset_i = 1'b0;

    // Coalescing: first hit at timestamp 100, second beam 3 cycles later.
    evt_ready_i = 1'b1;
    idle(100);
    pulse(2'b01);
    idle(2);
    pulse(2'b10);
    idle(10);

    // Second beam lands on the commit cycle and must be ignored.
    pulse(2'b01);
    idle(CC - 1);
    pulse(2'b10);
    idle(10);

    // Masked beam opens nothing; the other beam still does.
    mask_i = 2'b01;
    pulse(2'b01);
    idle(8);
    pulse(2'b11);
    idle(8);
    mask_i = 2'b00;

    // Overfill with 17 isolated events, then drain.
    evt_ready_i = 1'b0;
    repeat (FD + 1) begin
      pulse(2'b01);
      idle(CC + 2);
    end
    evt_ready_i = 1'b1;
    idle(FD + 4);

    // Fill to 16, then pop on the commit cycle of a 17th event.
    evt_ready_i = 1'b0;
    repeat (FD) begin
      pulse(2'b10);
      idle(CC + 2);
    end
    pulse(2'b11);
    idle(CC - 1);
    evt_ready_i = 1'b1;
    idle(1);
    evt_ready_i = 1'b0;
    idle(5);
    evt_ready_i = 1'b1;
    idle(FD + 4);

    // Reset during GATHER with data queued behind it.
    evt_ready_i = 1'b0;
    pulse(2'b01);
    idle(CC + 2);
    pulse(2'b10);
    idle(1);
    reset_i = 1'b1;
    idle(1);
    reset_i = 1'b0;
    evt_ready_i = 1'b1;
    idle(12);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      trigger_i   = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
      evt_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) mask_i = NB'($urandom);
      reset_i = ($urandom_range(0, 599) == 0);
      idle(1);
    end

    trigger_i   = '0;
    mask_i      = '0;
    reset_i     = 1'b0;
    evt_ready_i = 1'b1;
    idle(FD + 20);
    @(negedge aclk);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
